spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- 16-bit SPI mode-0 master that sits directly upstream of spi_slave.
- Generates sclk, cs and mosi from the system clock and captures miso.
- Presents a simple start/busy/done handshake toward the AHB-Lite side of the bridge.
- One transfer is one full-duplex frame of DATA_WIDTH bits, MSB first.

Parameters:
- DATA_WIDTH, 16, frame length in bits; must be at least 2.
- CLK_DIV, 5, sclk half-period in clk cycles; must be at least 2. The default gives a 5 MHz sclk from a 50 MHz clk.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a frame; sampled only in IDLE.
- tx_data  input  DATA_WIDTH  frame to transmit; captured on the cycle start is accepted.
- rx_data  output  DATA_WIDTH  last complete received frame.
- busy  output  1  high from start acceptance until the master is back in IDLE.
- done  output  1  one-cycle pulse when rx_data updates.
- sclk  output  1  SPI clock; idles low.
- cs  output  1  chip select, active low; idles high.
- mosi  output  1  serial data to slave.
- miso  input  1  serial data from slave.

Behaviour:
- Reset (rst=0, asynchronous) forces: sclk=0, cs=1, mosi=0, busy=0, done=0, rx_data=0, state=IDLE, divider and bit counters cleared.
- A reset mid-frame aborts the frame immediately. No done pulse is produced and rx_data is cleared to 0.
- State IDLE:
  - On start=1, tx_data loads the shift register.
  - On that same edge: cs drops to 0, mosi takes tx_data[DATA_WIDTH-1], busy goes to 1, and the state moves to SETUP.
  - start is ignored in every non-IDLE state; no queueing.
- State SETUP: holds for CLK_DIV cycles with sclk=0, giving the slave cs-to-first-edge setup time. Then goes to XFER.
- State XFER:
  - sclk toggles every CLK_DIV cycles, starting with a rising edge.
  - On each rising edge, miso is shifted into the LSB of the receive register.
  - On each falling edge, the next tx bit is driven on mosi, except after the last bit.
  - After DATA_WIDTH rising and DATA_WIDTH falling edges, sclk is low and the state moves to HOLD.
- State HOLD:
  - Holds for CLK_DIV cycles with cs still 0.
  - On exit: cs goes to 1, mosi goes to 0, rx_data takes the receive register, done=1 for exactly one cycle, and the state moves to GAP.
- State GAP: holds for CLK_DIV cycles with cs=1 and busy=1, guaranteeing minimum cs-high time. Then busy goes to 0 and the state moves to IDLE.
- Latency, counted from the clk edge that accepts start:
  - cs rises and done pulses at (2*DATA_WIDTH+2)*CLK_DIV cycles, i.e. 170 for the defaults.
  - busy falls CLK_DIV cycles later, i.e. 175.
- Back-to-back frames: start held high is accepted on the first IDLE cycle. The minimum start-to-start period is (2*DATA_WIDTH+3)*CLK_DIV+1 cycles.
- tx_data changing during a frame has no effect.
- rx_data is stable between done pulses.
- The divider counter wraps from CLK_DIV-1 to 0. The bit counter is sized for DATA_WIDTH*2 edges.

Optional Feature:
- Macro: SPI_MASTER_ABORT_EN.
- When defined, an input port abort (1 bit) is added.
  - abort=1 in SETUP, XFER or HOLD: on the next edge, sclk=0, cs=1, mosi=0, and the state moves to GAP.
  - done is not pulsed and rx_data is left unchanged.
  - abort in IDLE or GAP is ignored.
  - Abort takes priority over any same-cycle sclk edge.
- When undefined, there is no abort port and frames always run to completion.

Test Plan:
- Loopback: miso tied to mosi, tx_data=16'hA5A5, start pulse -> done at cycle 170, rx_data=16'hA5A5, exactly 16 sclk rising edges, busy low at cycle 175.
- Against spi_slave (slave tx_data=16'hFF00), master tx_data=16'h1234 -> master rx_data=16'hFF00, slave rx_data=16'h1234, cs low for exactly 170 cycles.
- start pulsed again at cycles 10 and 172 during a busy frame -> ignored: single done, second frame not started, cs stays high after GAP.
- start held high with tx_data=16'h0001 then 16'h8000 (loopback) -> two frames, rx_data=16'h0001 then 16'h8000, cs high at least 5 cycles between frames.
- rst driven low at cycle 60 of a frame -> cs=1, sclk=0, busy=0, rx_data=0 asynchronously, no done; a new frame with 16'hC3C3 after reset release returns 16'hC3C3.
- With SPI_MASTER_ABORT_EN: abort at cycle 50 of a frame whose preceding rx_data was 16'hA5A5 -> cs=1 next cycle, no done, rx_data stays 16'hA5A5, busy falls 5 cycles later.

Source files
------------

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// SPI mode-0 master (CPOL=0, CPHA=0) that drives one full-duplex frame of
// DATA_WIDTH bits, MSB first, per accepted start request.
//
// Frame timeline, counted in clk cycles from the edge that accepts start_i
// (D = CLK_DIV, W = DATA_WIDTH):
//   edge 0               cs_o falls, mosi_o = tx[W-1], busy_o rises (-> SETUP)
//   edge D               SETUP ends, sclk_o still low (-> XFER)
//   edges 2D .. (2W+1)D  2W sclk toggles, first one rising
//   edge (2W+2)D         HOLD ends: cs_o rises, done_o pulses, rx_data_o loads
//   edge (2W+3)D         GAP ends: busy_o falls (-> IDLE)
//
// Parameters:
//   DATA_WIDTH  frame length in bits (>= 2)
//   CLK_DIV     sclk half-period in clk cycles (>= 2)
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    frame request, only looked at in IDLE
//   tx_data_i  frame to send, captured when start_i is accepted
//   rx_data_o  last complete received frame
//   busy_o     high from start acceptance until back in IDLE
//   done_o     one-cycle pulse when rx_data_o updates
//   sclk_o     SPI clock, idles low
//   cs_o       chip select, active low, idles high
//   mosi_o     serial data to the slave
//   miso_i     serial data from the slave
//   abort_i    (only with SPI_MASTER_ABORT_EN) cancel the current frame
//
// Build option:
//   SPI_MASTER_ABORT_EN  adds abort_i. An abort in SETUP, XFER or HOLD drops
//                        sclk/mosi, raises cs and jumps to GAP without a done
//                        pulse and without touching rx_data_o.
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
`ifdef SPI_MASTER_ABORT_EN
    input  logic                  abort_i,
`endif
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  sclk_o,
    output logic                  cs_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    // Divider counts 0 .. CLK_DIV-1 inside every timed state.
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // Edge counter covers the 2*DATA_WIDTH sclk toggles of one frame.
    localparam int EDGE_W = $clog2(2 * DATA_WIDTH);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        GAP
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [EDGE_W-1:0]       edge_q, edge_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;        // MSB is the bit on mosi
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;        // receive shift register
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    sclk_q, sclk_d;
    logic                    cs_q, cs_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    div_last;
    logic                    abort_req;

`ifdef SPI_MASTER_ABORT_EN
    assign abort_req = abort_i;
`else
    assign abort_req = 1'b0;
`endif

    assign div_last = (div_q == DIV_LAST);

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                div_d  = '0;
                edge_d = '0;
                if (start_i) begin
                    // mosi_o is tx_q[MSB], so the first bit is on the wire
                    // together with the falling cs.
                    tx_d    = tx_data_i;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                div_d = div_last ? '0 : div_q + DIV_W'(1);
                if (div_last) begin
                    state_d = XFER;
                end
            end

            XFER: begin
                div_d = div_last ? '0 : div_q + DIV_W'(1);
                if (div_last) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EDGE_W'(1);
                    if (!sclk_q) begin
                        // Rising edge: sample the slave.
                        rx_d = {rx_q[DATA_WIDTH-2:0], miso_i};
                    end else if (edge_q != EDGE_LAST) begin
                        // Falling edge: present the next bit.
                        tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        // Final falling edge: the last bit stays on mosi
                        // through HOLD.
                        edge_d  = '0;
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                div_d = div_last ? '0 : div_q + DIV_W'(1);
                if (div_last) begin
                    cs_d      = 1'b1;
                    tx_d      = '0;
                    rx_data_d = rx_q;
                    done_d    = 1'b1;
                    state_d   = GAP;
                end
            end

            GAP: begin
                div_d = div_last ? '0 : div_q + DIV_W'(1);
                if (div_last) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything the active states decided this cycle,
        // including a pending sclk toggle or the HOLD-exit update.
        if (abort_req && ((state_q == SETUP) || (state_q == XFER) || (state_q == HOLD))) begin
            sclk_d    = 1'b0;
            cs_d      = 1'b1;
            tx_d      = '0;
            div_d     = '0;
            edge_d    = '0;
            rx_data_d = rx_data_q;
            done_d    = 1'b0;
            state_d   = GAP;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rx_data_o = rx_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign sclk_o    = sclk_q;
    assign cs_o      = cs_q;
    assign mosi_o    = tx_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// Directed bench for spi_master with the default parameters (16 bit frames,
// CLK_DIV = 5). A small behavioural SPI slave sits on the bus; miso_i is
// either looped back from mosi_o or driven by that slave.
// Define SPI_MASTER_ABORT_EN for both bench and RTL to exercise abort_i.
// -----------------------------------------------------------------------------
module tb_spi_master;

    localparam int W = 16;
    localparam int D = 5;
    localparam int T_DONE = (2 * W + 2) * D;   // 170
    localparam int T_IDLE = (2 * W + 3) * D;   // 175

    logic          clk;
    logic          rst_ni;
    logic          start_i;
    logic [W-1:0]  tx_data_i;
    logic [W-1:0]  rx_data_o;
    logic          busy_o;
    logic          done_o;
    logic          sclk_o;
    logic          cs_o;
    logic          mosi_o;
    logic          miso_i;
`ifdef SPI_MASTER_ABORT_EN
    logic          abort_i;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    spi_master #(
        .DATA_WIDTH (W),
        .CLK_DIV    (D)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
`ifdef SPI_MASTER_ABORT_EN
        .abort_i   (abort_i),
`endif
        .start_i   (start_i),
        .tx_data_i (tx_data_i),
        .rx_data_o (rx_data_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .sclk_o    (sclk_o),
        .cs_o      (cs_o),
        .mosi_o    (mosi_o),
        .miso_i    (miso_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural mode-0 slave ----------------
    logic          lb = 1'b1;            // 1: miso follows mosi
    logic [W-1:0]  s_tx_cfg = '0;
    logic [W-1:0]  s_sh = '0;
    logic [W-1:0]  s_rx = '0;
    logic          s_prev_cs = 1'b1;
    logic          s_prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (s_prev_cs && !cs_o) begin
            s_sh = s_tx_cfg;
            s_rx = '0;
        end else if (!cs_o) begin
            if (!s_prev_sclk && sclk_o) s_rx = {s_rx[W-2:0], mosi_o};
            if (s_prev_sclk && !sclk_o) s_sh = {s_sh[W-2:0], 1'b0};
        end
        s_prev_cs   = cs_o;
        s_prev_sclk = sclk_o;
    end

    assign miso_i = lb ? mosi_o : s_sh[W-1];

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // One complete frame, monitored for 190 cycles after the accept edge.
    // poke re-asserts start at cycles 10 and 172 while the master is busy.
    task automatic run_frame(input string tag, input logic [W-1:0] tx,
                             input logic [W-1:0] exp_rx, input logic [W-1:0] exp_srx,
                             input bit poke);
        int   done_cnt = 0;
        int   done_at  = -1;
        int   cs_up    = -1;
        int   busy_dn  = -1;
        int   rises    = 0;
        logic ps;
        @(negedge clk);
        tx_data_i = tx;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i   = 1'b0;
        tx_data_i = ~tx;                 // must not disturb the frame
        chk($sformatf("%s cs_fall", tag), 32'(cs_o), 32'(1'b0));
        chk($sformatf("%s busy_rise", tag), 32'(busy_o), 32'(1'b1));
        chk($sformatf("%s mosi_first", tag), 32'(mosi_o), 32'(tx[W-1]));
        ps = sclk_o;
        for (int c = 1; c <= 190; c++) begin
            @(posedge clk);
            #1;
            start_i = (poke && (c == 10 || c == 172)) ? 1'b1 : 1'b0;
            if (sclk_o && !ps) rises++;
            ps = sclk_o;
            if (done_o) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (cs_up < 0 && cs_o) cs_up = c;
            if (busy_dn < 0 && !busy_o) busy_dn = c;
        end
        start_i = 1'b0;
        chk($sformatf("%s done_cycle", tag), 32'(done_at), 32'(T_DONE));
        chk($sformatf("%s done_count", tag), 32'(done_cnt), 32'(1));
        chk($sformatf("%s sclk_rises", tag), 32'(rises), 32'(W));
        chk($sformatf("%s cs_low_cycles", tag), 32'(cs_up), 32'(T_DONE));
        chk($sformatf("%s busy_fall", tag), 32'(busy_dn), 32'(T_IDLE));
        chk($sformatf("%s rx_data", tag), 32'(rx_data_o), 32'(exp_rx));
        chk($sformatf("%s slave_rx", tag), 32'(s_rx), 32'(exp_srx));
        chk($sformatf("%s cs_idle_after", tag), 32'(cs_o), 32'(1'b1));
        chk($sformatf("%s busy_idle_after", tag), 32'(busy_o), 32'(1'b0));
    endtask

    typedef struct {
        logic [W-1:0] tx;
        logic [W-1:0] stx;
        logic         lb;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_srx;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   d1, d2, c2fall, cs_hi, cnt;
        logic [W-1:0] rx1, rx2, rx_mid;

        vecs[0] = '{tx: 16'hA5A5, stx: 16'h0000, lb: 1'b1, exp_rx: 16'hA5A5, exp_srx: 16'hA5A5};
        vecs[1] = '{tx: 16'h1234, stx: 16'hFF00, lb: 1'b0, exp_rx: 16'hFF00, exp_srx: 16'h1234};
        vecs[2] = '{tx: 16'h0000, stx: 16'hFFFF, lb: 1'b0, exp_rx: 16'hFFFF, exp_srx: 16'h0000};
        vecs[3] = '{tx: 16'hFFFF, stx: 16'h0001, lb: 1'b0, exp_rx: 16'h0001, exp_srx: 16'hFFFF};
        vecs[4] = '{tx: 16'h8000, stx: 16'h0000, lb: 1'b1, exp_rx: 16'h8000, exp_srx: 16'h8000};
        vecs[5] = '{tx: 16'h6B2D, stx: 16'h94D2, lb: 1'b0, exp_rx: 16'h94D2, exp_srx: 16'h6B2D};

        rst_ni    = 1'b0;
        start_i   = 1'b0;
        tx_data_i = '0;
`ifdef SPI_MASTER_ABORT_EN
        abort_i   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset sclk", 32'(sclk_o), 32'(1'b0));
        chk("reset cs", 32'(cs_o), 32'(1'b1));
        chk("reset mosi", 32'(mosi_o), 32'(1'b0));
        chk("reset busy", 32'(busy_o), 32'(1'b0));
        chk("reset done", 32'(done_o), 32'(1'b0));
        chk("reset rx_data", 32'(rx_data_o), 32'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);

        // ---- table-driven frames ----
        for (int i = 0; i < 6; i++) begin
            lb       = vecs[i].lb;
            s_tx_cfg = vecs[i].stx;
            run_frame($sformatf("vec%0d", i), vecs[i].tx, vecs[i].exp_rx, vecs[i].exp_srx, 1'b0);
        end

        // ---- start re-asserted while busy is ignored ----
        lb = 1'b1;
        run_frame("poke", 16'h3C3C, 16'h3C3C, 16'h3C3C, 1'b1);

        // ---- back-to-back with start held high ----
        d1 = -1; d2 = -1; c2fall = -1; cs_hi = 0;
        rx1 = '0; rx2 = '0; rx_mid = '0;
        @(negedge clk);
        tx_data_i = 16'h0001;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        tx_data_i = 16'h8000;
        for (int c = 1; c <= 360; c++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                if (d1 < 0) begin
                    d1 = c; rx1 = rx_data_o;
                end else if (d2 < 0) begin
                    d2 = c; rx2 = rx_data_o;
                end
            end
            if (c >= T_DONE && c2fall < 0) begin
                if (cs_o) cs_hi++;
                else c2fall = c;
            end
            if (c == 176) start_i = 1'b0;
            if (c == 250) rx_mid = rx_data_o;
        end
        chk("b2b done1_cycle", 32'(d1), 32'(T_DONE));
        chk("b2b rx1", 32'(rx1), 32'h0001);
        chk("b2b start2_cycle", 32'(c2fall), 32'(176));
        chk("b2b cs_high_gap", 32'(cs_hi), 32'(6));
        chk("b2b rx_stable", 32'(rx_mid), 32'h0001);
        chk("b2b done2_cycle", 32'(d2), 32'(176 + T_DONE));
        chk("b2b rx2", 32'(rx2), 32'h8000);

        // ---- asynchronous reset mid-frame ----
        @(negedge clk);
        tx_data_i = 16'h5A5A;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("midrst sclk_high_before", 32'(sclk_o), 32'(1'b1));
        rst_ni = 1'b0;
        #1;
        chk("midrst cs", 32'(cs_o), 32'(1'b1));
        chk("midrst sclk", 32'(sclk_o), 32'(1'b0));
        chk("midrst busy", 32'(busy_o), 32'(1'b0));
        chk("midrst rx_data", 32'(rx_data_o), 32'(0));
        chk("midrst mosi", 32'(mosi_o), 32'(1'b0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (done_o || !cs_o) cnt++;
        end
        chk("midrst no_done_no_cs", 32'(cnt), 32'(0));
        run_frame("after_rst", 16'hC3C3, 16'hC3C3, 16'hC3C3, 1'b0);

`ifdef SPI_MASTER_ABORT_EN
        // ---- abort during XFER, on a cycle that would toggle sclk ----
        run_frame("pre_abort", 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b0);
        cnt = 0;
        @(negedge clk);
        tx_data_i = 16'h5A5A;
        start_i   = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            abort_i = (c == 49) ? 1'b1 : 1'b0;
            if (done_o) cnt++;
            if (c == 50) begin
                chk("abort cs", 32'(cs_o), 32'(1'b1));
                chk("abort sclk", 32'(sclk_o), 32'(1'b0));
                chk("abort mosi", 32'(mosi_o), 32'(1'b0));
            end
            if (c == 54) chk("abort busy_still", 32'(busy_o), 32'(1'b1));
            if (c == 55) chk("abort busy_fall", 32'(busy_o), 32'(1'b0));
        end
        chk("abort no_done", 32'(cnt), 32'(0));
        chk("abort rx_kept", 32'(rx_data_o), 32'hA5A5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
